wb_port_arbiter: RTL

Round-robin arbiter sharing the register file's single 64-bit write port between two writeback requesters: req0 (ALU result) and req1 (load data). It sits between the execute/memory stages and the register file. It grants one requester per cycle over a valid/ready handshake and drives a registered write port (we/wa/wd) one cycle after the grant. It also supports a global stall input and optional XZR (X31) write suppression.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/wb_port_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the writeback port arbiter.
package wb_arb_pkg;

  localparam int NREQ      = 2;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 64;

  // Hard-wired zero register; writes to it may be filtered at the port.
  localparam logic [WB_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Arbitration state is decoded combinationally each cycle; nothing is stored.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    STALLED = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant. On a tie the requester
// that was not granted last wins; stall suppresses all grants.
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            last_grant,
  input  logic            stall,
  output logic [NREQ-1:0] grant,
  output arb_state_t      state
);

  // Decode arbitration state, then derive the one-hot grant from it.
  always_comb begin
    state = IDLE;
    grant = '0;
    if (stall) begin
      state = STALLED;
    end else begin
      case (valid)
        2'b01:   state = GRANT0;
        2'b10:   state = GRANT1;
        2'b11:   state = last_grant ? GRANT0 : GRANT1;
        default: state = IDLE;
      endcase
    end
    case (state)
      GRANT0:  grant = 2'b01;
      GRANT1:  grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file write port between the ALU
// (req0) and load (req1) writeback paths. Grant is combinational; the
// write port is registered one cycle after the grant.
// Optional macro WB_PORT_ARBITER_XZR_FILTER_EN: suppress rf_we for writes
// to X31 while still completing the handshake.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              last_grant
);

  logic [NREQ-1:0] grant;
  arb_state_t      state;
  logic            xfer;
  logic            gidx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .stall      (stall),
    .grant      (grant),
    .state      (state)
  );

  // Readies are held low during reset so no request is consumed then.
  assign req0_ready = grant[0] & reset;
  assign req1_ready = grant[1] & reset;

  // Select the granted request; transfer only outside reset.
  always_comb begin
    gidx     = (state == GRANT1);
    xfer     = reset & ((state == GRANT0) | (state == GRANT1));
    sel_addr = gidx ? req1_addr : req0_addr;
    sel_data = gidx ? req1_data : req0_data;
  end

  // Write port registers and fairness pointer; hold everything but we when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= gidx;
      rf_wa      <= sel_addr;
      rf_wd      <= sel_data;
`ifdef WB_PORT_ARBITER_XZR_FILTER_EN
      rf_we      <= (sel_addr != ADDR_W'(XZR_ADDR));
`else
      rf_we      <= 1'b1;
`endif
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule
